// File: rtl/sw_bt_conditioner_pkg.sv
// Shared constants and types for the switch/button conditioner.
package sw_bt_pkg;

  localparam int unsigned DB_CYCLES_DEF   = 10000;
  localparam int unsigned LONG_CYCLES_DEF = 1000000;
  localparam int unsigned REG_W           = 32;
  localparam int unsigned DB_CNT_W        = 32;

  // Counter field is sized for the largest filter; a channel only ever
  // advances the low $clog2(DB_CYCLES) bits and keeps the rest at zero.
  typedef struct packed {
    logic                q;
    logic [DB_CNT_W-1:0] cnt;
  } db_state_t;

endpackage

// File: rtl/sw_bt_conditioner_if.sv
// Peripheral-side signal bundle of the switch/button conditioner.
interface sw_bt_conditioner_if
  import sw_bt_pkg::*;
#(
  parameter int unsigned N_SW = 16,
  parameter int unsigned N_BT = 4
) ();

  logic [N_SW+N_BT-1:0] in;
  logic [N_BT-1:0]      ev_clr;
  logic [REG_W-1:0]     out_sw_bt;
  logic [N_BT-1:0]      ev_flags;
  logic [N_BT-1:0]      lp_flags;
  logic                 irq;

  modport master (
    output in, ev_clr,
    input  out_sw_bt, ev_flags, lp_flags, irq
  );

  modport slave (
    input  in, ev_clr,
    output out_sw_bt, ev_flags, lp_flags, irq
  );

endinterface

// File: rtl/sw_bt_conditioner_channel.sv
// One input channel: synchroniser chain followed by a counter-based debounce filter.
module sw_bt_channel
  import sw_bt_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic q_o
);

  localparam int unsigned CW = $clog2(DB_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  logic [CW-1:0]          cnt_inc;
  db_state_t              st_q, st_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
    s       = sync_q[SYNC_STAGES-1];
    cnt_inc = st_q.cnt[CW-1:0] + CW'(1);
    st_d    = st_q;
    if (s == st_q.q) begin
      st_d.cnt = '0;
    end else if (st_q.cnt == DB_CNT_W'(DB_CYCLES - 1)) begin
      st_d.q   = s;
      st_d.cnt = '0;
    end else begin
      st_d.cnt = DB_CNT_W'(cnt_inc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      st_q   <= '0;
    end else begin
      sync_q <= sync_d;
      st_q   <= st_d;
    end
  end

  assign q_o = st_q.q;

endmodule

// File: rtl/sw_bt_conditioner.sv
// Switch/button conditioner: debounced levels, sticky press flags and irq.
// Optional long-press detection is built when SWBT_LONG_PRESS_EN is defined.
module sw_bt_conditioner
  import sw_bt_pkg::*;
#(
  parameter int unsigned N_SW        = 16,
  parameter int unsigned N_BT        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sw_bt_conditioner_if.slave   bus
);

  localparam int unsigned N_CH = N_SW + N_BT;

  if (N_CH > REG_W) begin : g_err_width
    $error("sw_bt_conditioner: N_SW+N_BT must not exceed 32");
  end
  if (SYNC_STAGES < 2) begin : g_err_sync
    $error("sw_bt_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DB_CYCLES < 2) begin : g_err_db
    $error("sw_bt_conditioner: DB_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 1) begin : g_err_long
    $error("sw_bt_conditioner: LONG_CYCLES must be >= 1");
  end

  logic [N_CH-1:0] q_all;
  logic [N_BT-1:0] btn_q;
  logic [N_BT-1:0] btn_dly_q;
  logic [N_BT-1:0] ev_q, ev_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sw_bt_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_i (bus.in[i]),
      .q_o   (q_all[i])
    );
  end

  assign btn_q = q_all[N_CH-1:N_SW];

  // Rising edge of the debounced button level sets the flag; set beats clear.
  always_comb begin
    ev_d = (ev_q & ~bus.ev_clr) | (btn_q & ~btn_dly_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_dly_q <= '0;
      ev_q      <= '0;
    end else begin
      btn_dly_q <= btn_q;
      ev_q      <= ev_d;
    end
  end

`ifdef SWBT_LONG_PRESS_EN
  localparam int unsigned LW = $clog2(LONG_CYCLES + 1);

  logic [N_BT-1:0][LW-1:0] hold_q, hold_d;
  logic [N_BT-1:0]         lp_q, lp_d;

  // Hold counter saturates at LONG_CYCLES so the flag is set only once per press.
  always_comb begin
    hold_d = hold_q;
    lp_d   = lp_q & ~bus.ev_clr;
    for (int unsigned i = 0; i < N_BT; i++) begin
      if (!btn_q[i]) begin
        hold_d[i] = '0;
      end else if (hold_q[i] != LW'(LONG_CYCLES)) begin
        hold_d[i] = hold_q[i] + LW'(1);
        if (hold_q[i] == LW'(LONG_CYCLES - 1)) begin
          lp_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      lp_q   <= '0;
    end else begin
      hold_q <= hold_d;
      lp_q   <= lp_d;
    end
  end

  always_comb begin
    bus.lp_flags = lp_q;
    bus.irq      = (|ev_q) | (|lp_q);
  end
`else
  always_comb begin
    bus.lp_flags = '0;
    bus.irq      = |ev_q;
  end
`endif

  always_comb begin
    bus.out_sw_bt            = '0;
    bus.out_sw_bt[N_CH-1:0]  = q_all;
    bus.ev_flags             = ev_q;
  end

endmodule

// File: tb/tb_sw_bt_conditioner.sv
// Self-checking bench for sw_bt_conditioner: vector table, corner sequences, random vs model.
module tb_sw_bt_conditioner;

  localparam int unsigned N_SW = 16;
  localparam int unsigned N_BT = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DB   = 4;
  localparam int unsigned LONG = 8;
  localparam int unsigned N_CH = N_SW + N_BT;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N_CH-1:0] in_v = '0;
  logic [N_BT-1:0] clr_v = '0;

  sw_bt_conditioner_if #(.N_SW(N_SW), .N_BT(N_BT)) bus ();
  assign bus.in     = in_v;
  assign bus.ev_clr = clr_v;

  sw_bt_conditioner #(
    .N_SW        (N_SW),
    .N_BT        (N_BT),
    .SYNC_STAGES (SYNC),
    .DB_CYCLES   (DB),
    .LONG_CYCLES (LONG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a level is accepted once the synced input has disagreed
  // with it for DB consecutive edges; synced input is the raw value from SYNC edges ago.
  logic [N_CH-1:0] m_q, m_prev;
  logic [N_CH-1:0] m_hist[$];
  int unsigned     m_run[N_CH];
  logic [N_BT-1:0] m_ev, m_lp;
  int unsigned     m_hold[N_BT];

  task automatic model_reset();
    m_q = '0; m_prev = '0; m_ev = '0; m_lp = '0;
    m_hist.delete();
    for (int c = 0; c < N_CH; c++) m_run[c] = 0;
    for (int b = 0; b < N_BT; b++) m_hold[b] = 0;
  endtask

  task automatic model_step();
    logic [N_CH-1:0] s;
    logic [N_BT-1:0] bq, bprev;
    m_hist.push_back(in_v);
    if (m_hist.size() > SYNC) s = m_hist.pop_front();
    else s = '0;
    bq    = m_q[N_CH-1:N_SW];
    bprev = m_prev[N_CH-1:N_SW];
`ifdef SWBT_LONG_PRESS_EN
    begin
      logic [N_BT-1:0] lpset;
      lpset = '0;
      for (int b = 0; b < N_BT; b++) begin
        if (bq[b]) begin
          if (m_hold[b] < LONG) begin
            m_hold[b]++;
            if (m_hold[b] == LONG) lpset[b] = 1'b1;
          end
        end else begin
          m_hold[b] = 0;
        end
      end
      m_lp = (m_lp & ~clr_v) | lpset;
    end
`endif
    m_ev   = (m_ev & ~clr_v) | (bq & ~bprev);
    m_prev = m_q;
    for (int c = 0; c < N_CH; c++) begin
      if (s[c] !== m_q[c]) begin
        m_run[c]++;
        if (m_run[c] == DB) begin
          m_q[c]   = s[c];
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    in_v  = '0;
    clr_v = '0;
    rst_n = 1'b0;
    model_reset();
    ticks(2);
    rst_n = 1'b1;
  endtask

  task automatic cmp_model(input string name);
    check(name,
          {23'b0, bus.irq, bus.lp_flags, bus.ev_flags, bus.out_sw_bt},
          {23'b0, (|m_ev) | (|m_lp), m_lp, m_ev, 12'b0, m_q});
  endtask

  typedef struct {
    logic [N_CH-1:0] in;
    logic [N_BT-1:0] clr;
    int              cyc;
    logic [31:0]     exp_out;
    logic [N_BT-1:0] exp_ev;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{20'h00008, 4'h0, 5, 32'h0000_0000, 4'h0};
    tbl[1] = '{20'h00008, 4'h0, 1, 32'h0000_0008, 4'h0};
    tbl[2] = '{20'h10008, 4'h0, 6, 32'h0001_0008, 4'h0};
    tbl[3] = '{20'h10008, 4'h0, 1, 32'h0001_0008, 4'h1};
    tbl[4] = '{20'h10008, 4'h1, 1, 32'h0001_0008, 4'h0};
    tbl[5] = '{20'h00008, 4'h0, 6, 32'h0000_0008, 4'h0};
    tbl[6] = '{20'h00000, 4'h0, 6, 32'h0000_0000, 4'h0};

    #1 rst_n = 1'b0;
    #1;
    check("reset_state", {23'b0, bus.irq, bus.lp_flags, bus.ev_flags, bus.out_sw_bt}, 64'h0);

    // Table vectors
    do_reset();
    for (int i = 0; i < 7; i++) begin
      in_v  = tbl[i].in;
      clr_v = tbl[i].clr;
      ticks(tbl[i].cyc);
      check($sformatf("tbl%0d_out", i), {32'b0, bus.out_sw_bt}, {32'b0, tbl[i].exp_out});
      check($sformatf("tbl%0d_ev", i), {60'b0, bus.ev_flags}, {60'b0, tbl[i].exp_ev});
    end
    clr_v = '0;

    // Short glitch on a button never reaches the stable level
    do_reset();
    in_v[17] = 1'b1;
    ticks(3);
    in_v[17] = 1'b0;
    ticks(8);
    check("glitch_out", {32'b0, bus.out_sw_bt}, 64'h0);
    check("glitch_ev_irq", {59'b0, bus.irq, bus.ev_flags}, 64'h0);

    // Clear coinciding with the detected rising edge: set wins
    do_reset();
    in_v[17] = 1'b1;
    ticks(6);
    check("b1_level", {63'b0, bus.out_sw_bt[17]}, 64'h1);
    clr_v = 4'b0010;
    tick();
    check("setwins_ev", {60'b0, bus.ev_flags}, 64'h2);
    clr_v = '0;
    tick();
    check("setwins_hold", {60'b0, bus.ev_flags}, 64'h2);
    clr_v = 4'b0010;
    tick();
    clr_v = '0;
    check("clr_ev_irq", {59'b0, bus.irq, bus.ev_flags}, 64'h0);

    // Reset asserted mid-filter, then full latency again
    do_reset();
    in_v[19] = 1'b1;
    ticks(3);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset_zero", {23'b0, bus.irq, bus.lp_flags, bus.ev_flags, bus.out_sw_bt}, 64'h0);
    #3 rst_n = 1'b1;
    ticks(5);
    check("postreset_early", {63'b0, bus.out_sw_bt[19]}, 64'h0);
    tick();
    check("postreset_level", {63'b0, bus.out_sw_bt[19]}, 64'h1);

    // Long press
    do_reset();
    in_v[18] = 1'b1;
    ticks(6);
    check("lp_btn_level", {63'b0, bus.out_sw_bt[18]}, 64'h1);
`ifdef SWBT_LONG_PRESS_EN
    ticks(7);
    check("lp_before", {60'b0, bus.lp_flags}, 64'h0);
    tick();
    check("lp_set", {59'b0, bus.irq, bus.lp_flags}, 64'h14);
    clr_v = 4'b0100;
    tick();
    clr_v = '0;
    ticks(3);
    check("lp_cleared", {56'b0, bus.lp_flags, bus.ev_flags}, 64'h0);
`else
    ticks(20);
    check("lp_absent", {60'b0, bus.lp_flags}, 64'h0);
    check("lp_ev", {60'b0, bus.ev_flags}, 64'h4);
`endif

    // Randomised traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int unsigned den;
      den = ((cyc / 500) % 2 == 1) ? 3 : 12;
      for (int b = 0; b < N_CH; b++) begin
        if ($urandom_range(0, den - 1) == 0) in_v[b] = ~in_v[b];
      end
      clr_v = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      if (cyc == 2000) rst_n = 1'b0;
      if (cyc == 2002) rst_n = 1'b1;
      tick();
      cmp_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
